run_ctrl: RTL and testbench

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl_if.sv | 23 ++
 rtl/run_ctrl.sv | 149 ++++++++++++++
 tb/tb_run_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/run_ctrl_if.sv
// Preload handshake and data-memory port of run_ctrl.
// The master modport is the controller side; slave is the preload source / memory side.
interface run_ctrl_if;
    logic       pl_valid;
    logic       pl_ready;
    logic       pl_last;
    logic [7:0] pl_addr;
    logic [7:0] pl_data;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    modport master (
        input  pl_valid, pl_last, pl_addr, pl_data, mem_rdata,
        output pl_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output pl_valid, pl_last, pl_addr, pl_data, mem_rdata,
        input  pl_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/run_ctrl.sv
// Run controller: clears data memory, preloads it, releases the processor, then reads the result.
// Optional cycle counter output enabled by defining RUN_CTRL_CYCLE_COUNT_EN.
module run_ctrl #(
    parameter int unsigned RES_BASE       = 5,
    parameter int unsigned START_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go_i,
    output logic              start_o,
    input  logic              done_i,
    run_ctrl_if.master        pl_mem,
    output logic [31:0]       result_o,
    output logic              result_valid_o,
    output logic              busy_o,
    output logic              timeout_o,
    output logic [31:0]       cycle_count_o
);

    typedef enum logic [2:0] {
        StIdle, StClear, StPreload, StHold, StRun, StRead, StReport
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [31:0] run_cnt_q, run_cnt_d;
    logic [31:0] result_q, result_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  read_addr;

`ifdef RUN_CTRL_CYCLE_COUNT_EN
    logic [31:0] cc_q, cc_d;
    assign cycle_count_o = cc_q;
`else
    assign cycle_count_o = '0;
`endif

    assign read_addr = 8'(RES_BASE + 32'(idx_q[1:0]));
    assign result_o  = result_q;
    assign timeout_o = timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            run_cnt_q <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
`ifdef RUN_CTRL_CYCLE_COUNT_EN
            cc_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            run_cnt_q <= run_cnt_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
`ifdef RUN_CTRL_CYCLE_COUNT_EN
            cc_q      <= cc_d;
`endif
        end
    end

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        run_cnt_d        = run_cnt_q;
        result_d         = result_q;
        timeout_d        = timeout_q;
`ifdef RUN_CTRL_CYCLE_COUNT_EN
        cc_d             = cc_q;
`endif
        start_o          = 1'b1;
        busy_o           = 1'b1;
        result_valid_o   = 1'b0;
        pl_mem.pl_ready  = 1'b0;
        pl_mem.mem_we    = 1'b0;
        pl_mem.mem_addr  = '0;
        pl_mem.mem_wdata = '0;

        unique case (state_q)
            StIdle: begin
                busy_o = 1'b0;
                if (go_i) begin
                    state_d   = StClear;
                    idx_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            StClear: begin
                pl_mem.mem_we   = 1'b1;
                pl_mem.mem_addr = idx_q;
                idx_d           = idx_q + 8'd1;
                if (idx_q == 8'hFF) state_d = StPreload;
            end
            StPreload: begin
                pl_mem.pl_ready = 1'b1;
                if (pl_mem.pl_valid) begin
                    pl_mem.mem_we    = 1'b1;
                    pl_mem.mem_addr  = pl_mem.pl_addr;
                    pl_mem.mem_wdata = pl_mem.pl_data;
                    if (pl_mem.pl_last) begin
                        state_d   = StHold;
                        run_cnt_d = '0;
                    end
                end
            end
            StHold: begin
                if (run_cnt_q == 32'(START_CYCLES - 1)) begin
                    state_d   = StRun;
                    run_cnt_d = '0;
                end else begin
                    run_cnt_d = run_cnt_q + 32'd1;
                end
            end
            StRun: begin
                start_o = 1'b0;
                if (done_i) begin
                    state_d = StRead;
                    idx_d   = '0;
`ifdef RUN_CTRL_CYCLE_COUNT_EN
                    // Count includes the DONE cycle itself.
                    cc_d = (run_cnt_q == '1) ? '1 : run_cnt_q + 32'd1;
`endif
                end else if (run_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end else begin
                    run_cnt_d = run_cnt_q + 32'd1;
                end
            end
            StRead: begin
                pl_mem.mem_addr = read_addr;
                for (int k = 0; k < 4; k++) begin
                    if (idx_q[1:0] == 2'(k)) result_d[31-8*k -: 8] = pl_mem.mem_rdata;
                end
                idx_d = idx_q + 8'd1;
                if (idx_q[1:0] == 2'd3) state_d = StReport;
            end
            StReport: begin
                result_valid_o = 1'b1;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: two instances (default parameters, and wrapped base with short timeout)
// checked every cycle against a per-cycle expected timeline built from the transaction script.
module tb_run_ctrl;
    localparam int unsigned ABase = 5,   AStart = 2, ATo = 65535;
    localparam int unsigned BBase = 254, BStart = 3, BTo = 10;

    logic       clk = 1'b0, rst = 1'b1, go = 1'b0, done = 1'b0, sel = 1'b0;
    logic       pl_valid = 1'b0, pl_last = 1'b0;
    logic [7:0] pl_addr = '0, pl_data = '0;
    logic       proc_we = 1'b0;
    logic [7:0] proc_addr = '0, proc_data = '0;
    logic [7:0] mem [256];

    logic        start_a, start_b, rv_a, rv_b, busy_a, busy_b, to_a, to_b;
    logic [31:0] res_a, res_b, cc_a, cc_b;

    // Expected values for the cycle being sampled
    logic        chk_en = 1'b0;
    logic        e_start, e_busy, e_we, e_addr_chk, e_ready, e_rv;
    logic [7:0]  e_addr, e_wdata;
    logic [31:0] m_result [2];
    logic        m_timeout [2];
    logic [31:0] m_cc [2];
    int          n_pass = 0, n_total = 0, wr_cnt = 0;
    logic [7:0]  tab_a [4], tab_d [4];

    run_ctrl_if ifa ();
    run_ctrl_if ifb ();

    always #5 clk = ~clk;

    assign ifa.pl_valid = pl_valid;  assign ifb.pl_valid = pl_valid;
    assign ifa.pl_last  = pl_last;   assign ifb.pl_last  = pl_last;
    assign ifa.pl_addr  = pl_addr;   assign ifb.pl_addr  = pl_addr;
    assign ifa.pl_data  = pl_data;   assign ifb.pl_data  = pl_data;
    assign ifa.mem_rdata = mem[ifa.mem_addr];
    assign ifb.mem_rdata = mem[ifb.mem_addr];

    always @(posedge clk) begin
        if (ifa.mem_we)      mem[ifa.mem_addr] <= ifa.mem_wdata;
        else if (ifb.mem_we) mem[ifb.mem_addr] <= ifb.mem_wdata;
        else if (proc_we)    mem[proc_addr]    <= proc_data;
    end

    run_ctrl dut_a (
        .clk(clk), .reset(rst), .go_i(go & ~sel), .start_o(start_a), .done_i(done),
        .pl_mem(ifa), .result_o(res_a), .result_valid_o(rv_a), .busy_o(busy_a),
        .timeout_o(to_a), .cycle_count_o(cc_a)
    );

    run_ctrl #(.RES_BASE(BBase), .START_CYCLES(BStart), .TIMEOUT_CYCLES(BTo)) dut_b (
        .clk(clk), .reset(rst), .go_i(go & sel), .start_o(start_b), .done_i(done),
        .pl_mem(ifb), .result_o(res_b), .result_valid_o(rv_b), .busy_o(busy_b),
        .timeout_o(to_b), .cycle_count_o(cc_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("start", 32'(sel ? start_b : start_a), 32'(e_start));
            chk("busy", 32'(sel ? busy_b : busy_a), 32'(e_busy));
            chk("pl_ready", 32'(sel ? ifb.pl_ready : ifa.pl_ready), 32'(e_ready));
            chk("mem_we", 32'(sel ? ifb.mem_we : ifa.mem_we), 32'(e_we));
            if (e_addr_chk) chk("mem_addr", 32'(sel ? ifb.mem_addr : ifa.mem_addr), 32'(e_addr));
            if (e_we) chk("mem_wdata", 32'(sel ? ifb.mem_wdata : ifa.mem_wdata), 32'(e_wdata));
            chk("result_valid", 32'(sel ? rv_b : rv_a), 32'(e_rv));
            chk("timeout", 32'(sel ? to_b : to_a), 32'(m_timeout[sel]));
            chk("result", sel ? res_b : res_a, m_result[sel]);
            chk("cycle_count", sel ? cc_b : cc_a, m_cc[sel]);
            chk("other_busy", 32'(sel ? busy_a : busy_b), 32'd0);
            if (sel ? (ifb.mem_we && ifb.pl_ready) : (ifa.mem_we && ifa.pl_ready)) wr_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_set(input logic st, input logic bz, input logic we, input logic ac,
                           input logic [7:0] ad, input logic [7:0] wd, input logic rd,
                           input logic rv);
        e_start = st; e_busy = bz; e_we = we; e_addr_chk = ac;
        e_addr = ad; e_wdata = wd; e_ready = rd; e_rv = rv;
    endtask

    // One GO-to-IDLE transaction on the selected instance; done_at == 0 means DONE never comes.
    task automatic run_txn(input int nb, input bit toggle, input int done_at,
                           input logic [31:0] word, input bit go_noise, input bit done_in_hold);
        int unsigned base, scyc, toc;
        int k, pc, r;
        base = sel ? BBase : ABase;
        scyc = sel ? BStart : AStart;
        toc  = sel ? BTo : ATo;
        tick(); go = 1'b1; exp_set(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) begin
            tick(); go = go_noise && (i == 50); m_timeout[sel] = 1'b0;
            exp_set(1, 1, 1, 1, 8'(i), 8'h00, 0, 0);
        end
        k = 0; pc = 0;
        while (k < nb) begin
            tick();
            go       = go_noise && (pc == 1);
            pl_valid = !toggle || (pc % 2 == 0);
            pl_addr  = tab_a[k];
            pl_data  = tab_d[k];
            pl_last  = (k == nb - 1);
            exp_set(1, 1, pl_valid, pl_valid, tab_a[k], tab_d[k], 1, 0);
            if (pl_valid) k++;
            pc++;
        end
        for (int h = 0; h < int'(scyc); h++) begin
            tick(); pl_valid = 1'b0; pl_last = 1'b0; go = 1'b0; done = done_in_hold;
            exp_set(1, 1, 0, 0, 0, 0, 0, 0);
        end
        r = 1;
        forever begin
            tick();
            done      = (done_at != 0) && (r == done_at);
            proc_we   = (r <= 4);
            proc_addr = 8'(base + 32'(r - 1));
            proc_data = (r <= 4) ? word[31 - 8 * (r - 1) -: 8] : 8'h00;
            exp_set(0, 1, 0, 0, 0, 0, 0, 0);
            if (done || r == int'(toc)) break;
            r++;
        end
        if (!done) begin
            tick(); proc_we = 1'b0; m_timeout[sel] = 1'b1;
            exp_set(1, 0, 0, 0, 0, 0, 0, 0);
            return;
        end
`ifdef RUN_CTRL_CYCLE_COUNT_EN
        m_cc[sel] = 32'(done_at);
`endif
        for (int j = 0; j < 4; j++) begin
            tick(); done = 1'b0; proc_we = 1'b0;
            if (j > 0) m_result[sel][31 - 8 * (j - 1) -: 8] = word[31 - 8 * (j - 1) -: 8];
            exp_set(1, 1, 0, 1, 8'(base + 32'(j)), 0, 0, 0);
        end
        tick(); m_result[sel][7:0] = word[7:0];
        exp_set(1, 1, 0, 0, 0, 0, 0, 1);
        tick(); exp_set(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_result[i] = '0; m_timeout[i] = 1'b0; m_cc[i] = '0;
        end
        exp_set(1, 0, 0, 0, 0, 0, 0, 0);
        tick(); chk_en = 1'b1;
        tick(); proc_we = 1'b1; proc_addr = 8'd200; proc_data = 8'h77;
        tick(); proc_we = 1'b0; rst = 1'b0;
        tick();
        chk("dirty_mem200", 32'(mem[200]), 32'h77);

        // Basic run: preload two bytes, DONE on the 21st RUN cycle
        sel = 1'b0;
        tab_a[0] = 8'd0; tab_d[0] = 8'd85; tab_a[1] = 8'd1; tab_d[1] = 8'd5;
        run_txn(2, 0, 21, 32'h01020304, 0, 0);
        chk("t1_result_lit", res_a, 32'h01020304);
`ifdef RUN_CTRL_CYCLE_COUNT_EN
        chk("t1_cc_lit", cc_a, 32'd21);
`else
        chk("t1_cc_lit", cc_a, 32'd0);
`endif
        chk("t1_mem0", 32'(mem[0]), 32'd85);
        chk("t1_mem1", 32'(mem[1]), 32'd5);
        chk("t1_mem200_cleared", 32'(mem[200]), 32'd0);

        // Toggled PL_VALID, GO noise while busy, DONE high during HOLD
        tab_a[0] = 8'd20; tab_d[0] = 8'h11; tab_a[1] = 8'd21; tab_d[1] = 8'h22;
        tab_a[2] = 8'd22; tab_d[2] = 8'h33;
        wr_cnt = 0;
        run_txn(3, 1, 8, 32'hDEADBEEF, 1, 1);
        chk("t2_preload_writes", 32'(wr_cnt), 32'd3);
        chk("t2_mem22", 32'(mem[22]), 32'h33);
        chk("t2_result_lit", res_a, 32'hDEADBEEF);

        // Result address wraps past 255
        sel = 1'b1;
        tab_a[0] = 8'd10; tab_d[0] = 8'h5A;
        run_txn(1, 0, 6, 32'hAABBCCDD, 0, 0);
        chk("t3_result_lit", res_b, 32'hAABBCCDD);
        chk("t3_mem255", 32'(mem[255]), 32'hBB);

        // DONE never arrives: timeout after 10 RUN cycles, result untouched
        run_txn(1, 0, 0, 32'h99887766, 0, 0);
        chk("t4_timeout_lit", 32'(to_b), 32'd1);
        chk("t4_result_held", res_b, 32'hAABBCCDD);

        // Next GO clears TIMEOUT
        run_txn(1, 0, 5, 32'h11223344, 0, 0);
        chk("t5_timeout_lit", 32'(to_b), 32'd0);
        chk("t5_result_lit", res_b, 32'h11223344);

        // Reset in the middle of CLEAR, then a fresh run from address 0
        sel = 1'b0;
        tick(); go = 1'b1; exp_set(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i <= 100; i++) begin
            tick(); go = 1'b0; rst = (i == 100);
            exp_set(1, 1, 1, 1, 8'(i), 8'h00, 0, 0);
        end
        tick(); rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_result[i] = '0; m_timeout[i] = 1'b0; m_cc[i] = '0;
        end
        exp_set(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("t6_result_reset_lit", res_a, 32'd0);
        chk("t6_start_reset_lit", 32'(start_a), 32'd1);
        tab_a[0] = 8'd3; tab_d[0] = 8'h44;
        run_txn(1, 0, 9, 32'hCAFEF00D, 0, 0);
        chk("t6_result_lit", res_a, 32'hCAFEF00D);

        tick(); chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
